uart_tx_arbiter: RTL and testbench

Shares the single `tx_uart` transmitter between two byte-stream requesters, e.g. `ctrl_uart` result bytes and a status/echo source. Grants round-robin at message granularity: once a requester owns the line, its bytes go out back-to-back until it flags `last`. `tx_uart` has no busy output, so this block paces each byte with a frame-length timer before accepting the next one.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/frame_timer.sv | 34 +++
 rtl/uart_tx_arbiter.sv | 153 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and defaults for the tx_uart arbiter slice.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    HOLD = 2'd3
  } arb_state_e;

  localparam int unsigned CLK_FREQ_DEFAULT   = 50_000_000;
  localparam int unsigned BAUD_DEFAULT       = 9600;
  localparam int unsigned FRAME_BITS_DEFAULT = 10;

  // Cycles one tx_uart frame occupies the line, including trailing guard idle.
  function automatic int unsigned frame_cycles(input int unsigned clk_freq,
                                               input int unsigned baud,
                                               input int unsigned frame_bits,
                                               input int unsigned guard);
    return (clk_freq / baud) * frame_bits + guard;
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Loadable down-counter; done pulses for one cycle when a loaded count reaches zero.
module frame_timer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] value,
  output logic             done
);

  logic [WIDTH-1:0] count_q;
  logic             armed_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      armed_q <= 1'b0;
    end else if (clear) begin
      count_q <= '0;
      armed_q <= 1'b0;
    end else if (load) begin
      count_q <= value;
      armed_q <= 1'b1;
    end else if (armed_q) begin
      if (count_q == '0) armed_q <= 1'b0;
      else               count_q <= count_q - 1'b1;
    end
  end

  assign done = armed_q && (count_q == '0);

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin arbiter feeding a single tx_uart, paced by a frame timer.
// Optional HOLD abandonment timeout is built only when ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = CLK_FREQ_DEFAULT,
  parameter int unsigned BAUD         = BAUD_DEFAULT,
  parameter int unsigned FRAME_BITS   = FRAME_BITS_DEFAULT,
  parameter int unsigned GUARD_CYCLES = 2,
  parameter int unsigned HOLD_TIMEOUT = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic [7:0] tx_data,
  output logic       tx_ready,
  output logic [1:0] grant,
  output logic       busy,
  output logic       timeout
);

  localparam int unsigned FRAME_CYCLES = frame_cycles(CLK_FREQ, BAUD, FRAME_BITS, GUARD_CYCLES);
  localparam int unsigned FRAME_W      = $clog2(FRAME_CYCLES + 1);
  localparam logic [FRAME_W-1:0] FRAME_LOAD = FRAME_W'(FRAME_CYCLES - 1);

  arb_state_e state_q;
  logic       owner_q;
  logic       ptr_q;
  logic       last_q;
  logic [7:0] tx_data_q;
  logic       tx_ready_q;
  logic [1:0] grant_q;
  logic       busy_q;
  logic       timeout_q;

  logic       win;
  logic       owner_valid;
  logic [7:0] owner_data;
  logic       owner_last;
  logic       frame_done;
  logic       hold_expire;

  assign win         = (req0_valid && req1_valid) ? ptr_q : req1_valid;
  assign owner_valid = owner_q ? req1_valid : req0_valid;
  assign owner_data  = owner_q ? req1_data  : req0_data;
  assign owner_last  = owner_q ? req1_last  : req0_last;

  // Loaded during LOAD so the count expires on the last SEND cycle.
  frame_timer #(.WIDTH(FRAME_W)) u_frame_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (state_q == LOAD),
    .clear (1'b0),
    .value (FRAME_LOAD),
    .done  (frame_done)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned HOLD_W = $clog2(HOLD_TIMEOUT + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_TIMEOUT - 1);

  logic hold_start;
  logic hold_exit;

  assign hold_start = (state_q == SEND) && frame_done && !last_q && !owner_valid;
  assign hold_exit  = (state_q == HOLD) && owner_valid;

  frame_timer #(.WIDTH(HOLD_W)) u_hold_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (hold_start),
    .clear (hold_exit),
    .value (HOLD_LOAD),
    .done  (hold_expire)
  );
`else
  assign hold_expire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      ptr_q      <= 1'b0;
      last_q     <= 1'b0;
      tx_data_q  <= '0;
      tx_ready_q <= 1'b0;
      grant_q    <= '0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      tx_ready_q <= 1'b0;
      timeout_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req0_valid || req1_valid) begin
            owner_q <= win;
            grant_q <= win ? 2'b10 : 2'b01;
            busy_q  <= 1'b1;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          tx_data_q  <= owner_data;
          last_q     <= owner_last;
          tx_ready_q <= 1'b1;
          state_q    <= SEND;
        end
        SEND: begin
          if (frame_done) begin
            if (last_q) begin
              ptr_q   <= ~owner_q;
              grant_q <= '0;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else if (owner_valid) begin
              state_q <= LOAD;
            end else begin
              state_q <= HOLD;
            end
          end
        end
        HOLD: begin
          if (owner_valid) begin
            state_q <= LOAD;
          end else if (hold_expire) begin
            ptr_q     <= ~owner_q;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b1;
            state_q   <= IDLE;
          end
        end
      endcase
    end
  end

  assign req0_ready = (state_q == LOAD) && !owner_q;
  assign req1_ready = (state_q == LOAD) &&  owner_q;
  assign tx_data    = tx_data_q;
  assign tx_ready   = tx_ready_q;
  assign grant      = grant_q;
  assign busy       = busy_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter; the timeout scenario runs when ARB_TIMEOUT_EN is defined.
module tb_uart_tx_arbiter;

  // 1000 Hz / 100 baud -> 10 cycles/bit; 10 bits + 2 guard -> 102 cycles per frame
  localparam int FRAME = 102;
  localparam int HOLDT = 1000;

  logic       clk, rst;
  logic       req0_valid, req0_last, req0_ready;
  logic [7:0] req0_data;
  logic       req1_valid, req1_last, req1_ready;
  logic [7:0] req1_data;
  logic [7:0] tx_data;
  logic       tx_ready, busy, timeout;
  logic [1:0] grant;

  uart_tx_arbiter #(
    .CLK_FREQ     (1000),
    .BAUD         (100),
    .FRAME_BITS   (10),
    .GUARD_CYCLES (2),
    .HOLD_TIMEOUT (HOLDT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_last  (req0_last),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_last  (req1_last),
    .req1_ready (req1_ready),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .grant      (grant),
    .busy       (busy),
    .timeout    (timeout)
  );

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] g;
  } exp_t;

  exp_t       sb[$];
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  int         pulses[$];
  int         cyc = 0;
  int         checks = 0;
  int         passes = 0;
  int         n_timeout = 0;
  logic       rdy0_s = 1'b0;
  logic       rdy1_s = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push0(input logic [7:0] d, input logic l);
    q0.push_back({l, d});
  endtask

  task automatic push1(input logic [7:0] d, input logic l);
    q1.push_back({l, d});
  endtask

  task automatic expect_tx(input logic [7:0] d, input logic [1:0] g);
    sb.push_back('{d: d, g: g});
  endtask

  // Requester model: hold valid/data until ready was seen, then present the next queued byte.
  initial begin
    req0_valid = 1'b0; req0_data = '0; req0_last = 1'b0;
    req1_valid = 1'b0; req1_data = '0; req1_last = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (req0_valid && rdy0_s && q0.size() > 0) void'(q0.pop_front());
      if (req1_valid && rdy1_s && q1.size() > 0) void'(q1.pop_front());
      if (q0.size() > 0) begin
        req0_valid = 1'b1;
        {req0_last, req0_data} = q0[0];
      end else req0_valid = 1'b0;
      if (q1.size() > 0) begin
        req1_valid = 1'b1;
        {req1_last, req1_data} = q1[0];
      end else req1_valid = 1'b0;
    end
  end

  // Monitor: every tx_ready pulse must match the next scoreboard entry.
  initial forever begin
    exp_t e;
    @(negedge clk);
    rdy0_s = req0_ready;
    rdy1_s = req1_ready;
    if (timeout) n_timeout++;
    if (tx_ready) begin
      pulses.push_back(cyc);
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL tx_unexpected: got byte 0x%0h grant %b with nothing expected", tx_data, grant);
      end else begin
        e = sb.pop_front();
        check("tx_data", tx_data, e.d);
        check("tx_grant", grant, e.g);
      end
    end
  end

  task automatic do_reset();
    q0.delete();
    q1.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    pulses.delete();
  endtask

  task automatic wait_done(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && q0.size() == 0 && q1.size() == 0 && !busy) break;
    end
    if (i == budget) begin
      checks++;
      $display("FAIL wait_done: %0d bytes outstanding, busy=%b after %0d cycles", sb.size(), busy, budget);
    end
  endtask

  task automatic wait_pulses(input int n, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (pulses.size() >= n) break;
    end
    if (i == budget) begin
      checks++;
      $display("FAIL wait_pulse: got %0d pulses expected %0d", pulses.size(), n);
    end
  endtask

  initial begin
    int t;
    int bad;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_tx_data", tx_data, 0);
    check("rst_tx_ready", tx_ready, 0);
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout", timeout, 0);
    check("rst_ready0", req0_ready, 0);
    rst = 1'b1;

    // Single-byte message timing
    @(negedge clk);
    push0(8'h73, 1'b1);
    expect_tx(8'h73, 2'b01);
    t = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (req0_valid) begin t = cyc; break; end
    end
    check("t_valid_seen", (t >= 0) ? 1 : 0, 1);
    check("t0_ready0", req0_ready, 0);
    check("t0_busy", busy, 0);
    @(negedge clk);
    check("t1_ready0", req0_ready, 1);
    check("t1_grant", grant, 2'b01);
    check("t1_busy", busy, 1);
    @(negedge clk);
    check("t2_ready0", req0_ready, 0);
    check("t2_tx_ready", tx_ready, 1);
    @(negedge clk);
    check("t3_tx_ready", tx_ready, 0);
    repeat (FRAME - 2) @(negedge clk);
    check("send_end_busy", busy, 1);
    @(negedge clk);
    check("release_busy", busy, 0);
    check("release_grant", grant, 0);
    wait_done(20);

    // Both valid after reset: req0 message first, then req1
    do_reset();
    push0(8'h73, 1'b0);
    push0(8'h03, 1'b1);
    push1(8'h01, 1'b1);
    expect_tx(8'h73, 2'b01);
    expect_tx(8'h03, 2'b01);
    expect_tx(8'h01, 2'b10);
    wait_done(6 * FRAME);
    if (pulses.size() >= 3) begin
      check("gap_in_msg", pulses[1] - pulses[0], FRAME + 1);
      check("gap_new_msg", pulses[2] - pulses[1], FRAME + 2);
    end else begin
      checks++;
      $display("FAIL pulse_count: got %0d expected 3", pulses.size());
    end

    // Round-robin: after req0 is served, req1 wins a tie
    do_reset();
    push0(8'hA5, 1'b1);
    expect_tx(8'hA5, 2'b01);
    wait_done(3 * FRAME);
    push0(8'h5A, 1'b1);
    push1(8'hC3, 1'b1);
    expect_tx(8'hC3, 2'b10);
    expect_tx(8'h5A, 2'b01);
    wait_done(5 * FRAME);

    // Hold lock: req1 locked out while req0 idles mid-message
    do_reset();
    push0(8'h73, 1'b0);
    push1(8'h11, 1'b1);
    expect_tx(8'h73, 2'b01);
    wait_pulses(1, 20);
    repeat (FRAME + 2) @(negedge clk);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (req1_ready || grant != 2'b01 || !busy || tx_ready) bad++;
    end
    check("hold_violations", bad, 0);
    check("hold_grant", grant, 2'b01);
    push0(8'h01, 1'b1);
    expect_tx(8'h01, 2'b01);
    expect_tx(8'h11, 2'b10);
    wait_done(5 * FRAME);

`ifdef ARB_TIMEOUT_EN
    do_reset();
    n_timeout = 0;
    push0(8'h73, 1'b0);
    push1(8'h22, 1'b1);
    expect_tx(8'h73, 2'b01);
    expect_tx(8'h22, 2'b10);
    wait_pulses(1, 20);
    t = -1;
    for (int i = 0; i < FRAME + HOLDT + 200; i++) begin
      @(negedge clk);
      if (timeout) begin t = cyc; break; end
    end
    if (t < 0) begin
      checks++;
      $display("FAIL timeout_seen: no timeout pulse within budget");
    end else begin
      check("timeout_latency", t - pulses[0], FRAME + HOLDT);
      check("timeout_grant", grant, 0);
      check("timeout_busy", busy, 0);
      @(negedge clk);
      check("timeout_single", timeout, 0);
    end
    wait_done(4 * FRAME);
    check("timeout_count", n_timeout, 1);
`endif

    // Asynchronous reset during SEND, pointer back to req0
    do_reset();
    push0(8'h44, 1'b1);
    expect_tx(8'h44, 2'b01);
    wait_done(3 * FRAME);
    push0(8'h73, 1'b1);
    expect_tx(8'h73, 2'b01);
    wait_pulses(2, 20);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("arst_tx_data", tx_data, 0);
    check("arst_tx_ready", tx_ready, 0);
    check("arst_grant", grant, 0);
    check("arst_busy", busy, 0);
    check("arst_timeout", timeout, 0);
    check("arst_ready", {req0_ready, req1_ready}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    push0(8'h99, 1'b1);
    push1(8'h66, 1'b1);
    expect_tx(8'h99, 2'b01);
    expect_tx(8'h66, 2'b10);
    wait_done(5 * FRAME);

`ifndef ARB_TIMEOUT_EN
    check("no_timeout", n_timeout, 0);
`endif
    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
